// File: rtl/ucode_pkg.sv
// ucode_pkg: shared definitions for the D3-28 microprogram sequencer.
//   - sequencer state encoding (IDLE / FETCH / RUN)
//   - microword sequencing mode encodings (NEXT / JUMP / CJUMP / HALT)
//   - bit positions of the sequencing fields inside En[44:1]
//   - microaddress width and number of time phases per microcycle
//   - next_uaddr(): next microaddress from mode, current upc, NA and branch condition
package ucode_pkg;

  localparam int UADDR_W = 10;
  localparam int NPHASE  = 10;
  localparam int WORD_W  = 44;

  // Field positions use the En[44:1] numbering of the command bus.
  localparam int NA_HI   = 44;
  localparam int NA_LO   = 35;
  localparam int MODE_HI = 34;
  localparam int MODE_LO = 33;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_NEXT  = 2'b00,
    MODE_JUMP  = 2'b01,
    MODE_CJUMP = 2'b10,
    MODE_HALT  = 2'b11
  } mode_t;

  // HALT falls back to upc+1; the halt decision at t10 discards it anyway.
  function automatic logic [UADDR_W-1:0] next_uaddr(
    input mode_t              mode,
    input logic [UADDR_W-1:0] upc,
    input logic [UADDR_W-1:0] na,
    input logic               br
  );
    logic [UADDR_W-1:0] inc;
    inc = upc + UADDR_W'(1);
    case (mode)
      MODE_JUMP:  next_uaddr = na;
      MODE_CJUMP: next_uaddr = br ? na : inc;
      default:    next_uaddr = inc;
    endcase
  endfunction

endpackage

// File: rtl/ucode_tgen.sv
// ucode_tgen: time-strobe generator for the microprogram sequencer.
// The active-low strobe register is itself the one-hot phase ring, so tn is
// registered and glitch-free.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (all strobes high)
//   run      in   sequencer will be in RUN next cycle; low parks the ring (all high)
//   advance  in   step the ring this cycle (loads t1 when parked)
//   hold     in   keep the current phase (t6 wait stretch)
//   tn       out  [NPHASE:1] active-low one-hot strobes, tn[k]=0 during phase k
module ucode_tgen
  import ucode_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              advance,
  input  logic              hold,
  output logic [NPHASE:1]   tn
);

  localparam logic [NPHASE:1] TN_IDLE = '1;
  localparam logic [NPHASE:1] TN_T1   = {{(NPHASE-1){1'b1}}, 1'b0};

  // Parked ring (all ones) enters at t1; otherwise the low bit rotates upward
  // and t10 wraps back to t1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tn <= TN_IDLE;
    end else if (!run) begin
      tn <= TN_IDLE;
    end else if (hold) begin
      tn <= tn;
    end else if (advance) begin
      if (&tn) begin
        tn <= TN_T1;
      end else begin
        tn <= {tn[NPHASE-1:1], tn[NPHASE]};
      end
    end
  end

endmodule

// File: rtl/ucode_seq.sv
// ucode_seq: microprogram sequencer for the D3-28 control unit.
// Fetches 44-bit microwords from a synchronous control-store ROM (1-clock
// latency), holds the current word on En[44:1], produces the active-low time
// strobes tn[10:1] and computes the next microaddress from the word's
// NA (En[44:35]) and mode (En[34:33]) fields.
// Build option: define UCODE_SEQ_WAIT_EN to let wait_n=0 stretch phase t6;
// without it wait_n is unused and every microcycle is 10 clocks.
// Ports:
//   main_clk   in   sole clock
//   resn       in   asynchronous active-low reset
//   start      in   begin execution at START_ADDR (honoured in IDLE only)
//   halt_req   in   stop after the current microcycle (sampled at end of t10)
//   wait_n     in   memory/tape ready, low stretches t6
//   br_cond    in   branch condition (sampled at end of t8)
//   cs_addr    out  [9:0] control-store address
//   cs_data    in   [43:0] control-store word, valid one clock after cs_addr
//   En         out  [44:1] current microword
//   tn         out  [10:1] active-low time strobes
//   cycle_end  out  high during t10
//   running    out  high when not IDLE
module ucode_seq
  import ucode_pkg::*;
#(
  parameter logic [UADDR_W-1:0] START_ADDR = 10'h000
) (
  input  logic                main_clk,
  input  logic                resn,
  input  logic                start,
  input  logic                halt_req,
  input  logic                wait_n,
  input  logic                br_cond,
  output logic [UADDR_W-1:0]  cs_addr,
  input  logic [WORD_W-1:0]   cs_data,
  output logic [WORD_W:1]     En,
  output logic [NPHASE:1]     tn,
  output logic                cycle_end,
  output logic                running
);

  state_t             state_q, state_d;
  logic [UADDR_W-1:0] upc_q, nxt_q;
  logic               load_word;
  logic               tg_run, tg_advance, stretch;
  logic               at_t6, at_t8, at_t9, at_t10;
  mode_t              mode;
  logic               halt_now;

  assign at_t6  = ~tn[6];
  assign at_t8  = ~tn[8];
  assign at_t9  = ~tn[9];
  assign at_t10 = ~tn[10];

  assign mode     = mode_t'(En[MODE_HI:MODE_LO]);
  assign halt_now = (mode == MODE_HALT) || halt_req;

`ifdef UCODE_SEQ_WAIT_EN
  assign stretch = at_t6 & ~wait_n;
`else
  logic unused_wait_n;
  assign unused_wait_n = wait_n;
  assign stretch       = 1'b0;
`endif

  always_ff @(posedge main_clk or negedge resn) begin
    if (!resn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // t10 is never stretched, so testing at_t10 in RUN fires exactly once per
  // microcycle; a halt there returns to IDLE without loading a new word.
  always_comb begin
    state_d   = state_q;
    load_word = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d   = ST_RUN;
        load_word = 1'b1;
      end
      ST_RUN: begin
        if (at_t10) begin
          if (halt_now) begin
            state_d = ST_IDLE;
          end else begin
            load_word = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The ring follows the next state so tn[1] drops on the same edge that
  // enters RUN, and all strobes rise on the edge that returns to IDLE.
  assign tg_run     = (state_d == ST_RUN);
  assign tg_advance = (state_q != ST_IDLE);

  // cs_addr presents nxt from t9 so the ROM word is ready for the t10->t1 edge.
  always_comb begin
    cs_addr = START_ADDR;
    if (state_q == ST_RUN) begin
      cs_addr = (at_t9 || at_t10) ? nxt_q : upc_q;
    end
  end

  assign running   = (state_q != ST_IDLE);
  assign cycle_end = at_t10;

  always_ff @(posedge main_clk or negedge resn) begin
    if (!resn) begin
      En    <= '0;
      upc_q <= '0;
      nxt_q <= '0;
    end else begin
      if ((state_q == ST_RUN) && at_t8) begin
        nxt_q <= next_uaddr(mode, upc_q, En[NA_HI:NA_LO], br_cond);
      end
      if (load_word) begin
        En    <= cs_data;
        upc_q <= (state_q == ST_FETCH) ? START_ADDR : nxt_q;
      end
    end
  end

  ucode_tgen u_tgen (
    .clk     (main_clk),
    .rst_n   (resn),
    .run     (tg_run),
    .advance (tg_advance),
    .hold    (stretch),
    .tn      (tn)
  );

endmodule
